riscv_muldiv: RTL and testbench
===============================

# riscv_muldiv

Iterative RV32M multiply/divide execution unit sitting directly downstream of the RISC-V register bank. Consumes the two source-operand read ports (rs1D, rs2D) plus destination index and funct3. Computes the M-extension result over multiple cycles, one bit per cycle, then presents a single-cycle write-back pulse (RWr, rd, WBDat) that feeds the register bank's write port through the write-back mux.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ce  in  1  clock enable; when low, all state is frozen (same ce as register bank).
- start  in  1  request; sampled only in IDLE with ce=1.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1D  in  32  operand A (multiplicand/dividend).
- rs2D  in  32  operand B (multiplier/divisor).
- rdIn  in  5  destination register index.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- RWr  out  1  write-back strobe = done AND (rdOut != 0).
- rdOut  out  5  captured destination index.
- WBDat  out  32  result; held until next completion.

## Operation
- States: IDLE, RUN, DONE. Transitions occur only on edges with ce=1.
- IDLE: on start=1, capture funct3, rdIn, rs1D, rs2D, and operand signs; load magnitudes; clear iteration counter (6 bits). Next state is RUN, or DONE directly for fast-path cases.
- Fast path (direct to DONE, no iterations):
  - Divide by zero (rs2D=0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1D.
  - Signed overflow for DIV/REM (rs1D=0x80000000, rs2D=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- RUN, multiply: shift-add on unsigned magnitudes into a 64-bit accumulator, one multiplier bit per cycle, 32 iterations.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats A as signed, B unsigned; MULHU treats both unsigned.
  - Final sign fix: negate the 64-bit product if the operand signs differ.
  - MUL returns product[31:0]; MULH* return product[63:32].
- RUN, divide: restoring division on magnitudes, 32 iterations.
  - Signed ops: quotient negated if signs differ; remainder takes the dividend's sign.
  - Unsigned ops use raw values.
- RUN leaves to DONE after iteration 32 (counter = 31 at edge). Sign fix is applied on that transition.
- DONE: done=1, RWr=1 if rdOut!=0, WBDat valid. Next state is always IDLE.
- start is ignored while busy; a new start is accepted in the cycle after DONE.
- rd=0: done still pulses, RWr stays 0, WBDat still updates.

## Timing
- Reset values: state IDLE; busy=0, done=0, RWr=0, rdOut=0, WBDat=0; accumulators and counter 0.
- Iterative latency: start sampled at edge E; done high in the cycle after edge E+33 (33 ce-enabled edges later).
- Fast-path latency: done high in the cycle after edge E+1.
- ce=0 stretches latency cycle-for-cycle. done, RWr and busy hold their value while ce=0, so a stalled DONE keeps done high until the next ce=1 edge.
- Reset mid-operation: immediate return to IDLE, no RWr pulse, WBDat cleared.
- Operands may change after the start edge; the unit uses its captured copies.
- Throughput: one operation per 34 cycles (iterative) or 2 cycles (fast path).

## Configuration
- Macro: RISCV_MULDIV_DIV_EN.
- Defined: full DIV/DIVU/REM/REMU support as above.
- Undefined: divider datapath not built.
  - funct3[2]=1 takes the fast path with result 0; done pulses normally and RWr follows the rd!=0 rule.
  - Multiply ops are unchanged.

## Test plan
- MUL, rs1D=7, rs2D=0xFFFFFFFD (-3), rd=5 -> done after 33 edges, RWr=1, rdOut=5, WBDat=0xFFFFFFEB.
- MULH, 0x80000000 × 0x80000000 -> WBDat=0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV, rs2D=0 -> done one cycle after start, WBDat=0xFFFFFFFF. REMU 100 by 0 -> WBDat=100.
- DIV, 0x80000000 by 0xFFFFFFFF -> fast path, WBDat=0x80000000. REM -7 by 2 -> WBDat=0xFFFFFFFF (-1). REMU 100 by 7 -> 2.
- MUL with ce held low for 5 cycles mid-RUN -> done arrives 5 cycles later; result is identical. start pulsed while busy -> ignored.
- Assert rst at iteration 10, rd=3 -> busy=0 immediately, no RWr pulse, WBDat=0. With rd=0 -> done=1, RWr=0.

Source files
------------

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide unit, one bit per cycle, single-cycle write-back pulse.
// Divider datapath is built only when RISCV_MULDIV_DIV_EN is defined; otherwise divide ops return 0.
module riscv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1D,
    input  logic [XLEN-1:0]   rs2D,
    input  logic [4:0]        rdIn,
    output logic              busy,
    output logic              done,
    output logic              RWr,
    output logic [4:0]        rdOut,
    output logic [XLEN-1:0]   WBDat
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   a, b, res_q, fast_res, abs_a, abs_b, mul_res, res;
    logic [2*XLEN-1:0] acc, acc_nx, mul_nx, prod;
    logic [XLEN:0]     mul_sum;
    logic [5:0]        cnt;
    logic              neg_a, neg_b, sa, sb, fast;
    assign sa    = rs1D[XLEN-1] & (funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11));
    assign sb    = rs2D[XLEN-1] & (funct3[2] ? !funct3[0] : !funct3[1]);
    assign abs_a = sa ? -rs1D : rs1D;
    assign abs_b = sb ? -rs2D : rs2D;
`ifdef RISCV_MULDIV_DIV_EN
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] div_nx;
    logic [XLEN-1:0]   q, r, div_res;
    assign fast     = funct3[2] && (rs2D == '0 || (!funct3[0] && rs1D == 32'h8000_0000 && rs2D == 32'hFFFF_FFFF));
    assign fast_res = (rs2D == '0) ? (funct3[1] ? rs1D : '1) : (funct3[1] ? '0 : 32'h8000_0000);
    // Restoring step: shift {rem,quot} left, keep the trial difference when it does not borrow.
    assign div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b0, b};
    assign div_nx   = {div_diff[XLEN+1] ? acc[2*XLEN-2:XLEN-1] : div_diff[XLEN-1:0], acc[XLEN-2:0], !div_diff[XLEN+1]};
    assign acc_nx   = op[2] ? div_nx : mul_nx;
    assign q        = acc_nx[XLEN-1:0];
    assign r        = acc_nx[2*XLEN-1:XLEN];
    assign div_res  = op[1] ? (neg_a ? -r : r) : ((neg_a ^ neg_b) ? -q : q);
    assign res      = op[2] ? div_res : mul_res;
`else
    assign fast     = funct3[2];
    assign fast_res = '0;
    assign acc_nx   = mul_nx;
    assign res      = mul_res;
`endif
    // Shift-add: add multiplicand into the upper half, then shift the whole accumulator right.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (b[0] ? a : '0)};
    assign mul_nx  = {mul_sum, acc[XLEN-1:1]};
    assign prod    = (neg_a ^ neg_b) ? -acc_nx : acc_nx;
    assign mul_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (start ? (fast ? DONE : RUN) : IDLE)
                 : (state == RUN)  ? ((cnt == 6'd31) ? DONE : RUN)
                 : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else if (ce) state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op    <= '0;
            rd_q  <= '0;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            res_q <= '0;
        end else if (ce) begin
            if (state == IDLE && start) begin
                op    <= funct3;
                rd_q  <= rdIn;
                neg_a <= sa;
                neg_b <= sb;
                a     <= abs_a;
                b     <= abs_b;
                acc   <= funct3[2] ? {{XLEN{1'b0}}, abs_a} : '0;
                cnt   <= '0;
                if (fast) res_q <= fast_res;
            end else if (state == RUN) begin
                acc <= acc_nx;
                b   <= op[2] ? b : b >> 1;
                cnt <= cnt + 6'd1;
                if (cnt == 6'd31) res_q <= res;
            end
        end
    end
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    assign RWr   = done && rd_q != 5'd0;
    assign rdOut = rd_q;
    assign WBDat = res_q;
endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: directed self-checking bench for riscv_muldiv (multiply, divide, stalls, reset).
module tb_riscv_muldiv;
    logic        clk = 1'b0, rst = 1'b1, ce = 1'b1, start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1D = '0, rs2D = '0;
    logic [4:0]  rdIn = '0;
    logic        busy, done, RWr;
    logic [4:0]  rdOut;
    logic [31:0] WBDat;
    int tests = 0, fails = 0;
`ifdef RISCV_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int DIV_EDGES = DIV_EN ? 33 : 1;

    always #5 clk = ~clk;

    riscv_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .funct3(funct3),
        .rs1D(rs1D), .rs2D(rs2D), .rdIn(rdIn), .busy(busy), .done(done),
        .RWr(RWr), .rdOut(rdOut), .WBDat(WBDat)
    );

    // Presents a request for one edge, then scrambles operands to prove they were captured.
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
        @(negedge clk);
        funct3 = f; rs1D = x; rs2D = y; rdIn = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rs1D = 32'hDEAD_BEEF; rs2D = 32'h1234_5678; rdIn = 5'd0; funct3 = 3'd1;
    endtask

    task automatic wait_done(input int e0, output int edges);
        edges = e0;
        while (done !== 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_op(input string name, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                           input logic [4:0] r, input int exp_edges, input logic [31:0] exp);
        int e;
        issue(f, x, y, r);
        wait_done(1, e);
        tests++;
        if (e !== exp_edges) begin fails++; $display("FAIL %s latency: got %0d edges, want %0d", name, e, exp_edges); end
        tests++;
        if (WBDat !== exp) begin fails++; $display("FAIL %s WBDat: got %h, want %h", name, WBDat, exp); end
        tests++;
        if (RWr !== (r != 5'd0) || rdOut !== r) begin
            fails++; $display("FAIL %s writeback: RWr=%b rdOut=%0d, want RWr=%b rdOut=%0d", name, RWr, rdOut, r != 5'd0, r);
        end
    endtask

    task automatic test_reset;
        tests++;
        if ({busy, done, RWr, rdOut, WBDat} !== 40'd0) begin
            fails++; $display("FAIL reset_state: busy=%b done=%b RWr=%b rdOut=%0d WBDat=%h, want all 0", busy, done, RWr, rdOut, WBDat);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, done, RWr, WBDat} !== 35'd0) begin
            fails++; $display("FAIL idle_after_reset: busy=%b done=%b RWr=%b WBDat=%h, want 0", busy, done, RWr, WBDat);
        end
    endtask

    task automatic test_mul;
        test_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 33, 32'hFFFF_FFEB);
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || RWr !== 1'b0 || WBDat !== 32'hFFFF_FFEB) begin
            fails++; $display("FAIL mul_pulse_end: done=%b busy=%b RWr=%b WBDat=%h, want 0 0 0 ffffffeb", done, busy, RWr, WBDat);
        end
        test_op("mul_big", 3'b000, 32'h0001_0001, 32'h0001_0001, 5'd9, 33, 32'h0002_0001);
    endtask

    task automatic test_mulh;
        test_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 33, 32'h4000_0000);
        test_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 33, 32'hFFFF_FFFE);
        test_op("mulhsu_neg_a", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 33, 32'hFFFF_FFFF);
        test_op("mulhsu_uns_b", 3'b010, 32'd2, 32'hFFFF_FFFF, 5'd4, 33, 32'h0000_0001);
        test_op("mulhu_carry", 3'b011, 32'h8000_0000, 32'd2, 5'd6, 33, 32'h0000_0001);
    endtask

    task automatic test_div;
        test_op("div_by_zero", 3'b100, 32'd55, 32'd0, 5'd7, 1, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
        test_op("remu_by_zero", 3'b111, 32'd100, 32'd0, 5'd8, 1, DIV_EN ? 32'd100 : 32'd0);
        test_op("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1, DIV_EN ? 32'h8000_0000 : 32'd0);
        test_op("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1, 32'd0);
        test_op("rem_neg7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, DIV_EDGES, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
        test_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd12, DIV_EDGES, DIV_EN ? 32'd2 : 32'd0);
        test_op("div_neg7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd13, DIV_EDGES, DIV_EN ? 32'hFFFF_FFFD : 32'd0);
        test_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd14, DIV_EDGES, DIV_EN ? 32'd14 : 32'd0);
    endtask

    task automatic test_ce;
        int e;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; rs1D = 32'd1; rs2D = 32'd0; rdIn = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        wait_done(15, e);
        tests++;
        if (e !== 38) begin fails++; $display("FAIL ce_stall latency: got %0d edges, want 38", e); end
        tests++;
        if (WBDat !== 32'hFFFF_FFEB || rdOut !== 5'd5) begin
            fails++; $display("FAIL ce_stall result: WBDat=%h rdOut=%0d, want ffffffeb 5", WBDat, rdOut);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL start_while_busy: busy=%b, want 0", busy); end
        issue(3'b100, 32'd1, 32'd0, 5'd15);
        wait_done(1, e);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (done !== 1'b1 || RWr !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL done_stall: done=%b RWr=%b busy=%b, want 1 1 1", done, RWr, busy);
        end
        ce = 1'b1;
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL done_release: done=%b busy=%b, want 0 0", done, busy); end
    endtask

    task automatic test_back_to_back;
        test_op("b2b_first", 3'b100, 32'd3, 32'd0, 5'd1, 1, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
        test_op("b2b_second", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 33, 32'hFFFF_FFFE);
    endtask

    task automatic test_rst_mid;
        int rwr_cnt = 0;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3);
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, RWr, rdOut, WBDat} !== 40'd0) begin
            fails++; $display("FAIL rst_mid: busy=%b done=%b RWr=%b rdOut=%0d WBDat=%h, want all 0", busy, done, RWr, rdOut, WBDat);
        end
        @(negedge clk); rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (RWr === 1'b1 || done === 1'b1) rwr_cnt++;
        end
        tests++;
        if (rwr_cnt !== 0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_no_wb: pulses=%0d busy=%b, want 0 0", rwr_cnt, busy);
        end
    endtask

    task automatic test_rd0;
        test_op("mul_rd0", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd0, 33, 32'hFFFF_FFEB);
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL rd0_done: done=%b, want 1", done); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_mul;
        test_mulh;
        test_div;
        test_ce;
        test_back_to_back;
        test_rst_mid;
        test_rd0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
